// File: rtl/ex_stage_unit_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
// The master side drives ID/EX, forwarding and stall/flush; the slave side is the execute stage.
interface ex_stage_unit_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] ex_pc_plus_4;
  logic [XLEN-1:0] ex_read_data1;
  logic [XLEN-1:0] ex_read_data2;
  logic [XLEN-1:0] ex_immediate;
  logic [4:0]      ex_rd_addr;
  logic            ex_alu_src;
  logic [4:0]      ex_alu_op;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_reg_write;
  logic [1:0]      fwd_a_sel;
  logic [1:0]      fwd_b_sel;
  logic [XLEN-1:0] wb_data;
  logic            ex_flush;
  logic            mem_stall;
  logic            ex_busy;
  logic [XLEN-1:0] mem_pc_plus_4;
  logic [XLEN-1:0] mem_alu_result;
  logic [XLEN-1:0] mem_store_data;
  logic [4:0]      mem_rd_addr;
  logic            mem_mem_read;
  logic            mem_mem_write;
  logic            mem_reg_write;

  modport master (
    output ex_pc_plus_4, ex_read_data1, ex_read_data2, ex_immediate, ex_rd_addr, ex_alu_src,
           ex_alu_op, ex_mem_read, ex_mem_write, ex_reg_write, fwd_a_sel, fwd_b_sel, wb_data,
           ex_flush, mem_stall,
    input  ex_busy, mem_pc_plus_4, mem_alu_result, mem_store_data, mem_rd_addr, mem_mem_read,
           mem_mem_write, mem_reg_write
  );

  modport slave (
    input  ex_pc_plus_4, ex_read_data1, ex_read_data2, ex_immediate, ex_rd_addr, ex_alu_src,
           ex_alu_op, ex_mem_read, ex_mem_write, ex_reg_write, fwd_a_sel, fwd_b_sel, wb_data,
           ex_flush, mem_stall,
    output ex_busy, mem_pc_plus_4, mem_alu_result, mem_store_data, mem_rd_addr, mem_mem_read,
           mem_mem_write, mem_reg_write
  );
endinterface

// File: rtl/ex_stage_unit.sv
// Execute stage: operand forwarding, ALU, single-cycle multiplier, iterative radix-2
// restoring divider and the EX/MEM pipeline register.
module ex_stage_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input logic          clk,
    input logic          rst,
    ex_stage_unit_if.slave bus
);
    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
    localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_PASSB = 5'd10;
    localparam logic [4:0] OP_MUL = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19;
    localparam logic [4:0] OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM = 5'd22, OP_REMU = 5'd23;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc_plus_4;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd_addr;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
    } exmem_t;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] quo, rem, dvs;
    logic            q_neg, r_neg, d_rem;
    exmem_t          exmem_q;

    logic [XLEN-1:0] op_a, store_data, op_b, alu_res, ex_result, div_special, div_res;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [XLEN:0]   trial, diff;
    logic            is_div, div_signed, div_is_rem, div_zero, div_ovf, div_start;
    logic [4:0]      shamt;

    always_comb begin
        case (bus.fwd_a_sel)
            2'b01:   op_a = bus.mem_alu_result;
            2'b10:   op_a = bus.wb_data;
            default: op_a = bus.ex_read_data1;
        endcase
        case (bus.fwd_b_sel)
            2'b01:   store_data = bus.mem_alu_result;
            2'b10:   store_data = bus.wb_data;
            default: store_data = bus.ex_read_data2;
        endcase
        op_b  = bus.ex_alu_src ? bus.ex_immediate : store_data;
        shamt = op_b[4:0];
    end

    // One multiplier; the operand extension selects signed/unsigned high-half flavours.
    always_comb begin
        mul_a = {{XLEN{op_a[XLEN-1] & (bus.ex_alu_op == OP_MULH || bus.ex_alu_op == OP_MULHSU)}}, op_a};
        mul_b = {{XLEN{op_b[XLEN-1] & (bus.ex_alu_op == OP_MULH)}}, op_b};
        prod  = mul_a * mul_b;
    end

    always_comb begin
        case (bus.ex_alu_op)
            OP_ADD:    alu_res = op_a + op_b;
            OP_SUB:    alu_res = op_a - op_b;
            OP_SLL:    alu_res = op_a << shamt;
            OP_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU:   alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_XOR:    alu_res = op_a ^ op_b;
            OP_SRL:    alu_res = op_a >> shamt;
            OP_SRA:    alu_res = XLEN'($signed(op_a) >>> shamt);
            OP_OR:     alu_res = op_a | op_b;
            OP_AND:    alu_res = op_a & op_b;
            OP_PASSB:  alu_res = op_b;
            OP_MUL:    alu_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: alu_res = prod[2*XLEN-1:XLEN];
            default:   alu_res = '0;
        endcase
    end

    always_comb begin
        is_div     = (bus.ex_alu_op == OP_DIV) || (bus.ex_alu_op == OP_DIVU) ||
                     (bus.ex_alu_op == OP_REM) || (bus.ex_alu_op == OP_REMU);
        div_signed = (bus.ex_alu_op == OP_DIV) || (bus.ex_alu_op == OP_REM);
        div_is_rem = (bus.ex_alu_op == OP_REM) || (bus.ex_alu_op == OP_REMU);
        div_zero   = (op_b == '0);
        div_ovf    = div_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        div_start  = (state == S_IDLE) && is_div && !bus.ex_flush && !div_zero && !div_ovf;
        a_abs      = (div_signed && op_a[XLEN-1]) ? -op_a : op_a;
        b_abs      = (div_signed && op_b[XLEN-1]) ? -op_b : op_b;
        // Divide-by-zero and signed overflow resolve without iterating.
        if (div_zero) div_special = div_is_rem ? op_a : '1;
        else          div_special = div_is_rem ? '0 : op_a;
        div_res    = d_rem ? (r_neg ? -rem : rem) : (q_neg ? -quo : quo);
        if (state == S_DONE) ex_result = div_res;
        else if (is_div)     ex_result = div_special;
        else                 ex_result = alu_res;
        trial      = {rem, quo[XLEN-1]};
        diff       = trial - {1'b0, dvs};
    end

    assign bus.ex_busy = !rst && !bus.ex_flush && (div_start || state == S_BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            d_rem <= 1'b0;
        end else if (bus.ex_flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (div_start) begin
                    quo   <= a_abs;
                    rem   <= '0;
                    dvs   <= b_abs;
                    q_neg <= div_signed && (op_a[XLEN-1] ^ op_b[XLEN-1]);
                    r_neg <= div_signed && op_a[XLEN-1];
                    d_rem <= div_is_rem;
                    cnt   <= CNT_W'(XLEN-1);
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    // diff's top bit clear means the trial remainder covers the divisor.
                    if (!diff[XLEN]) begin
                        rem <= diff[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= trial[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                    if (cnt == '0) state <= S_DONE;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                S_DONE: if (!bus.mem_stall) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   exmem_q <= '0;
        else if (bus.ex_flush)                     exmem_q <= '0;
        else if (bus.mem_stall)                    exmem_q <= exmem_q;
        else if (div_start || state == S_BUSY)     exmem_q <= '0;
        else begin
            exmem_q.pc_plus_4  <= bus.ex_pc_plus_4;
            exmem_q.alu_result <= ex_result;
            exmem_q.store_data <= store_data;
            exmem_q.rd_addr    <= bus.ex_rd_addr;
            exmem_q.mem_read   <= bus.ex_mem_read;
            exmem_q.mem_write  <= bus.ex_mem_write;
            exmem_q.reg_write  <= bus.ex_reg_write;
        end
    end

    assign bus.mem_pc_plus_4  = exmem_q.pc_plus_4;
    assign bus.mem_alu_result = exmem_q.alu_result;
    assign bus.mem_store_data = exmem_q.store_data;
    assign bus.mem_rd_addr    = exmem_q.rd_addr;
    assign bus.mem_mem_read   = exmem_q.mem_read;
    assign bus.mem_mem_write  = exmem_q.mem_write;
    assign bus.mem_reg_write  = exmem_q.reg_write;
endmodule

// File: tb/tb_ex_stage_unit.sv
// Bench for ex_stage_unit: vector table through a result scoreboard, plus flush,
// operand-capture, stall-in-DONE and reset-abort sequences.
module tb_ex_stage_unit;
    localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLL = 5'd2, SLT = 5'd3, SLTU = 5'd4, XOR_ = 5'd5;
    localparam logic [4:0] SRL = 5'd6, SRA = 5'd7, OR_ = 5'd8, AND_ = 5'd9, PASSB = 5'd10;
    localparam logic [4:0] MUL = 5'd16, MULH = 5'd17, MULHSU = 5'd18, MULHU = 5'd19;
    localparam logic [4:0] DIV = 5'd20, DIVU = 5'd21, REM = 5'd22, REMU = 5'd23;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b;
        logic [1:0]  fa, fb;
        logic        src;
        logic [31:0] imm, wb, exp;
        int          busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_stage_unit_if #(.XLEN(32)) bus ();
    ex_stage_unit #(.XLEN(32), .CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] sb[$];
    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(logic [4:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] exp,
                                int busy = 0, logic [1:0] fa = 2'b00, logic [1:0] fb = 2'b00,
                                logic src = 1'b0, logic [31:0] imm = 32'd0, logic [31:0] wb = 32'd0);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp; v.busy = busy;
        v.fa = fa; v.fb = fb; v.src = src; v.imm = imm; v.wb = wb;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.ex_alu_op = v.op;  bus.ex_read_data1 = v.a; bus.ex_read_data2 = v.b;
        bus.fwd_a_sel = v.fa;  bus.fwd_b_sel = v.fb;    bus.ex_alu_src = v.src;
        bus.ex_immediate = v.imm; bus.wb_data = v.wb;
        bus.ex_reg_write = 1'b1; bus.ex_rd_addr = 5'd9; bus.ex_pc_plus_4 = 32'h104;
        sb.push_back(v.exp);
    endtask

    task automatic idle();
        bus.ex_alu_op = ADD; bus.ex_reg_write = 1'b0; bus.ex_rd_addr = 5'd0;
        bus.fwd_a_sel = 2'b00; bus.fwd_b_sel = 2'b00; bus.ex_alu_src = 1'b0;
    endtask

    // Waits for a writeback-valid EX/MEM entry and checks it against the scoreboard head.
    task automatic wait_result(input string name);
        bit done = 0;
        logic [31:0] exp;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk); #1;
            if (bus.mem_reg_write) done = 1;
        end
        exp = sb.pop_front();
        chk({name, " done"}, 32'(done), 32'd1);
        if (done) chk(name, bus.mem_alu_result, exp);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int busy = 0;
        bit done = 0, bub_bad = 0;
        logic [31:0] exp;
        @(negedge clk);
        drive(v);
        for (int c = 0; c < 60 && !done; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (bus.ex_busy) busy++;
            @(posedge clk); #1;
            if (bus.mem_reg_write) done = 1;
            else if (bus.mem_alu_result !== 32'd0 || bus.mem_rd_addr !== 5'd0) bub_bad = 1;
        end
        exp = sb.pop_front();
        chk({name, " done"}, 32'(done), 32'd1);
        if (done) begin
            chk(name, bus.mem_alu_result, exp);
            chk({name, " busy"}, 32'(busy), 32'(v.busy));
            if (v.busy > 0) chk({name, " bubble"}, 32'(bub_bad), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.ex_flush = 1'b0; bus.mem_stall = 1'b0;
        bus.ex_mem_read = 1'b0; bus.ex_mem_write = 1'b1;
        bus.ex_immediate = 32'd0; bus.wb_data = 32'd0;
        // Live, nonzero inputs during reset must not leak into EX/MEM.
        bus.ex_alu_op = ADD; bus.ex_read_data1 = 32'd11; bus.ex_read_data2 = 32'd22;
        bus.fwd_a_sel = 2'b00; bus.fwd_b_sel = 2'b00; bus.ex_alu_src = 1'b0;
        bus.ex_reg_write = 1'b1; bus.ex_rd_addr = 5'd4; bus.ex_pc_plus_4 = 32'h40;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset alu_result", bus.mem_alu_result, 32'd0);
        chk("reset ctrl", {bus.mem_reg_write, bus.mem_mem_write, bus.mem_mem_read, bus.ex_busy}, 32'd0);
        chk("reset pc", bus.mem_pc_plus_4, 32'd0);
        @(negedge clk);
        bus.ex_mem_write = 1'b0;
        idle();
        rst = 1'b0;

        vt.push_back(mk(ADD,   32'd3, 32'd4, 32'd7));
        vt.push_back(mk(SUB,   32'd5, 32'd7, 32'hFFFFFFFE));
        vt.push_back(mk(SLL,   32'd1, 32'h3F, 32'h80000000));
        vt.push_back(mk(SLT,   32'hFFFFFFFF, 32'd0, 32'd1));
        vt.push_back(mk(SLTU,  32'hFFFFFFFF, 32'd0, 32'd0));
        vt.push_back(mk(XOR_,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0));
        vt.push_back(mk(SRL,   32'h80000000, 32'd4, 32'h08000000));
        vt.push_back(mk(SRA,   32'h80000000, 32'd4, 32'hF8000000));
        vt.push_back(mk(OR_,   32'hF0, 32'h0F, 32'hFF));
        vt.push_back(mk(AND_,  32'hF0, 32'h3C, 32'h30));
        vt.push_back(mk(PASSB, 32'd123, 32'd0, 32'hABCDE000, 0, 2'b00, 2'b00, 1'b1, 32'hABCDE000));
        vt.push_back(mk(ADD,   32'd2, 32'd3, 32'd5));
        vt.push_back(mk(ADD,   32'hDEAD, 32'd7, 32'd12, 0, 2'b01));
        vt.push_back(mk(ADD,   32'd0, 32'd0, 32'd2000, 0, 2'b10, 2'b10, 1'b0, 32'd0, 32'd1000));
        vt.push_back(mk(ADD,   32'd10, 32'd5, 32'd15, 0, 2'b11, 2'b11));
        vt.push_back(mk(MUL,   32'd7, 32'd6, 32'd42));
        vt.push_back(mk(MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1));
        vt.push_back(mk(MULH,  32'h80000000, 32'd2, 32'hFFFFFFFF));
        vt.push_back(mk(MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF));
        vt.push_back(mk(MULHSU, 32'd2, 32'hFFFFFFFF, 32'd1));
        vt.push_back(mk(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE));
        vt.push_back(mk(DIVU,  32'd100, 32'd7, 32'd14, 33));
        vt.push_back(mk(REMU,  32'd100, 32'd7, 32'd2, 33));
        vt.push_back(mk(DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33));
        vt.push_back(mk(REM,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33));
        vt.push_back(mk(DIV,   32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33));
        vt.push_back(mk(REM,   32'd7, 32'hFFFFFFFE, 32'd1, 33));
        vt.push_back(mk(DIV,   32'd5, 32'd0, 32'hFFFFFFFF, 0));
        vt.push_back(mk(REMU,  32'd5, 32'd0, 32'd5, 0));
        vt.push_back(mk(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0));
        vt.push_back(mk(REM,   32'h80000000, 32'hFFFFFFFF, 32'd0, 0));
        vt.push_back(mk(DIVU,  32'h80000000, 32'hFFFFFFFF, 32'd0, 33));
        vt.push_back(mk(5'd11, 32'd9, 32'd9, 32'd0));
        vt.push_back(mk(5'd31, 32'd9, 32'd9, 32'd0));

        foreach (vt[i]) run_vec(vt[i], $sformatf("vec%0d op%0d", i, vt[i].op));
        chk("vec rd", 32'(bus.mem_rd_addr), 32'd9);
        chk("vec pc", bus.mem_pc_plus_4, 32'h104);
        @(negedge clk); idle();

        // Flush at BUSY cycle 10 discards the divide; the following ADD runs normally.
        @(negedge clk);
        drive(mk(DIV, 32'hFFFFFF9C, 32'd7, 32'd0));
        void'(sb.pop_back());
        repeat (10) @(negedge clk);
        #1 chk("pre-flush busy", 32'(bus.ex_busy), 32'd1);
        bus.ex_flush = 1'b1;
        #1 chk("flush busy", 32'(bus.ex_busy), 32'd0);
        @(posedge clk); #1;
        chk("flush bubble", {bus.mem_alu_result[30:0], bus.mem_reg_write}, 32'd0);
        @(negedge clk);
        bus.ex_flush = 1'b0;
        drive(mk(ADD, 32'd20, 32'd22, 32'd42));
        #1 chk("post-flush busy", 32'(bus.ex_busy), 32'd0);
        wait_result("post-flush add");

        // Operands change on the forwarding path after issue; the result must not.
        @(negedge clk);
        drive(mk(DIVU, 32'd100, 32'd7, 32'd14));
        repeat (3) @(negedge clk);
        bus.ex_read_data1 = 32'd1000; bus.ex_read_data2 = 32'd3;
        wait_result("capture divu");

        // mem_stall while in DONE: EX/MEM holds its bubble until the stall drops.
        @(negedge clk);
        drive(mk(DIVU, 32'd100, 32'd7, 32'd14));
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (!bus.ex_busy) break;
        end
        bus.mem_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("stall hold %0d", k), {bus.mem_alu_result[30:0], bus.mem_reg_write}, 32'd0);
            chk($sformatf("stall busy %0d", k), 32'(bus.ex_busy), 32'd0);
        end
        @(negedge clk);
        bus.mem_stall = 1'b0;
        @(posedge clk); #1;
        chk("stall result", bus.mem_alu_result, sb.pop_front());
        chk("stall wb", 32'(bus.mem_reg_write), 32'd1);

        // Reset mid-divide clears everything immediately and leaves the FSM idle.
        @(negedge clk);
        drive(mk(DIVU, 32'd100, 32'd7, 32'd0));
        void'(sb.pop_back());
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst busy", 32'(bus.ex_busy), 32'd0);
        chk("rst outs", {bus.mem_alu_result[30:0], bus.mem_reg_write}, 32'd0);
        @(negedge clk);
        idle();
        rst = 1'b0;
        run_vec(mk(ADD, 32'd1, 32'd2, 32'd3), "post-rst add");
        run_vec(mk(DIVU, 32'd100, 32'd7, 32'd14, 33), "post-rst divu");
        @(negedge clk); idle();
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
